// File: rtl/line_buffer.sv
// line_buffer: DEPTH-word sliding delay line; optional fill count output under LINE_BUFFER_COUNT_EN
module line_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_wr_valid,
  input  logic [WIDTH-1:0]           i_wr_data,
  output logic                       o_rd_valid,
`ifdef LINE_BUFFER_COUNT_EN
  output logic [$clog2(DEPTH+1)-1:0] o_count,
`endif
  output logic [WIDTH-1:0]           o_rd_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  // pixel storage, deliberately unreset; it is only read once every slot has been written
  always_ff @(posedge i_clk)
    if (i_wr_valid && !i_reset) mem[wr_ptr] <= i_wr_data;
  // pointer wraps at DEPTH-1, fill count saturates, valid latches when the last slot fills
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      wr_ptr     <= '0;
      cnt        <= '0;
      o_rd_valid <= 1'b0;
    end else if (i_wr_valid) begin
      wr_ptr     <= wr_ptr == PW'(DEPTH-1) ? '0 : wr_ptr + PW'(1);
      cnt        <= cnt == CW'(DEPTH) ? cnt : cnt + CW'(1);
      o_rd_valid <= o_rd_valid | (cnt == CW'(DEPTH-1));
    end
  // once full, the write pointer addresses the oldest word
  assign o_rd_data = o_rd_valid ? mem[wr_ptr] : '0;
`ifdef LINE_BUFFER_COUNT_EN
  assign o_count = cnt;
`endif
endmodule

// File: tb/tb_line_buffer.sv
// tb_line_buffer: directed self-checking bench for line_buffer (DEPTH=8, WIDTH=8)
module tb_line_buffer;
  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_wr_valid = 1'b0;
  logic [7:0] i_wr_data = '0;
  logic       o_rd_valid;
  logic [7:0] o_rd_data;
`ifdef LINE_BUFFER_COUNT_EN
  logic [3:0] o_count;
`endif
  int checks = 0;
  int failures = 0;

  line_buffer #(.WIDTH(8), .DEPTH(8)) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_wr_valid(i_wr_valid),
    .i_wr_data(i_wr_data),
    .o_rd_valid(o_rd_valid),
`ifdef LINE_BUFFER_COUNT_EN
    .o_count(o_count),
`endif
    .o_rd_data(o_rd_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    i_wr_valid = v;
    i_wr_data  = d;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_valid", o_rd_valid, 0);
    check("rst_data", o_rd_data, 0);
`ifdef LINE_BUFFER_COUNT_EN
    check("rst_count", o_count, 0);
`endif
    i_reset = 1'b0;
    step(0, 0);
    step(0, 0);
    check("idle_valid", o_rd_valid, 0);
    check("idle_data", o_rd_data, 0);
    for (int i = 0; i < 7; i++) begin
      step(1, 8'(i));
      check($sformatf("fill%0d_valid", i + 1), o_rd_valid, 0);
      check($sformatf("fill%0d_data", i + 1), o_rd_data, 0);
`ifdef LINE_BUFFER_COUNT_EN
      check($sformatf("fill%0d_count", i + 1), o_count, 32'(i + 1));
`endif
    end
    step(1, 7);
    check("full_valid", o_rd_valid, 1);
    check("full_data", o_rd_data, 0);
`ifdef LINE_BUFFER_COUNT_EN
    check("full_count", o_count, 8);
`endif
    for (int k = 1; k <= 16; k++) begin
      step(1, 8'(7 + k));
      check($sformatf("alt%0d_valid", k), o_rd_valid, 1);
      check($sformatf("alt%0d_data", k), o_rd_data, 32'(k));
      step(0, 8'hff);
      check($sformatf("alt%0d_hold_valid", k), o_rd_valid, 1);
      check($sformatf("alt%0d_hold_data", k), o_rd_data, 32'(k));
    end
`ifdef LINE_BUFFER_COUNT_EN
    check("sat_count", o_count, 8);
`endif
    i_reset = 1'b1;
    step(0, 0);
    i_reset = 1'b0;
    check("rst2_valid", o_rd_valid, 0);
`ifdef LINE_BUFFER_COUNT_EN
    check("rst2_count", o_count, 0);
`endif
    for (int n = 1; n <= 20; n++) begin
      step(1, 8'(n - 1));
      check($sformatf("burst%0d_valid", n), o_rd_valid, n >= 8 ? 1 : 0);
      check($sformatf("burst%0d_data", n), o_rd_data, n >= 8 ? 32'(n - 8) : 0);
    end
    step(0, 0);
    check("pre_async_valid", o_rd_valid, 1);
    check("pre_async_data", o_rd_data, 12);
    #2 i_reset = 1'b1;
    #1;
    check("async_valid", o_rd_valid, 0);
    check("async_data", o_rd_data, 0);
`ifdef LINE_BUFFER_COUNT_EN
    check("async_count", o_count, 0);
`endif
    @(posedge i_clk);
    #1 i_reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(1, 8'(100 + i));
      check($sformatf("refill%0d_valid", i + 1), o_rd_valid, 0);
      check($sformatf("refill%0d_data", i + 1), o_rd_data, 0);
    end
    step(1, 107);
    check("refill8_valid", o_rd_valid, 1);
    check("refill8_data", o_rd_data, 100);
    step(1, 108);
    check("refill9_data", o_rd_data, 101);
    step(0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
